// File: rtl/core_pkg.sv
// Shared opcode, FSM-state, counter-command and instruction-field definitions for the 16-bit core sequencer.
package core_pkg;

    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_ADD   = 5'h01;
    localparam logic [4:0] OP_SUB   = 5'h02;
    localparam logic [4:0] OP_MUL   = 5'h03;
    localparam logic [4:0] OP_AND   = 5'h04;
    localparam logic [4:0] OP_OR    = 5'h05;
    localparam logic [4:0] OP_XOR   = 5'h06;
    localparam logic [4:0] OP_SHL   = 5'h07;
    localparam logic [4:0] OP_SHR   = 5'h08;
    localparam logic [4:0] OP_MOV   = 5'h09;
    localparam logic [4:0] OP_CMPEQ = 5'h0A;
    localparam logic [4:0] OP_CMPLT = 5'h0B;
    localparam logic [4:0] OP_CMPGT = 5'h0C;
    localparam logic [4:0] OP_CSET  = 5'h0D;
    localparam logic [4:0] OP_CINC  = 5'h0E;
    localparam logic [4:0] OP_CDEC  = 5'h0F;
    localparam logic [4:0] OP_ADDC  = 5'h10;
    localparam logic [4:0] OP_HALT  = 5'h1F;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_DECODE   = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_WAIT_ALU = 3'd4;
    localparam logic [2:0] ST_WB       = 3'd5;
    localparam logic [2:0] ST_HALT     = 3'd6;

    localparam logic [1:0] CNT_NONE = 2'b00;
    localparam logic [1:0] CNT_SET  = 2'b01;
    localparam logic [1:0] CNT_INC  = 2'b10;
    localparam logic [1:0] CNT_DEC  = 2'b11;

    localparam int F_OP_LSB = 0;
    localparam int F_RD_LSB = 5;
    localparam int F_RA_LSB = 8;
    localparam int F_RB_LSB = 11;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_CMP,
        CL_CNT,
        CL_HALT,
        CL_ILL
    } op_class_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-memory fetch port plus ALU / register-file control bundle; master = sequencer side.
interface alu_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [15:0]     imem_data;
    logic [7:0]      alu_op;
    logic            alu_start;
    logic            alu_done;
    logic [2:0]      rf_ra;
    logic [2:0]      rf_rb;
    logic [2:0]      rf_wa;
    logic            rf_we;
    logic            flag_we;
    logic [1:0]      cnt_op;

    modport master (
        output imem_req, imem_addr, alu_op, alu_start, rf_ra, rf_rb, rf_wa, rf_we, flag_we, cnt_op,
        input  imem_valid, imem_data, alu_done
    );

    modport slave (
        input  imem_req, imem_addr, alu_op, alu_start, rf_ra, rf_rb, rf_wa, rf_we, flag_we, cnt_op,
        output imem_valid, imem_data, alu_done
    );
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational opcode classifier: zero latency, no state, no backpressure.
module alu_seq_decode
    import core_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_e  op_class,
    output logic [7:0] alu_op,
    output logic       rf_we,
    output logic       flag_we,
    output logic [1:0] cnt_op,
    output logic       is_mul,
    output logic       is_halt,
    output logic       is_illegal
);
    always_comb begin
        op_class   = CL_ILL;
        rf_we      = 1'b0;
        flag_we    = 1'b0;
        cnt_op     = CNT_NONE;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (opcode == OP_NOP) begin
            op_class = CL_NOP;
        end else if (opcode inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
                                    OP_SHL, OP_SHR, OP_MOV, OP_ADDC}) begin
            op_class = CL_ALU;
            rf_we    = 1'b1;
        end else if (opcode inside {OP_CMPEQ, OP_CMPLT, OP_CMPGT}) begin
            op_class = CL_CMP;
            flag_we  = 1'b1;
        end else if (opcode == OP_CSET) begin
            op_class = CL_CNT;
            cnt_op   = CNT_SET;
        end else if (opcode == OP_CINC) begin
            op_class = CL_CNT;
            cnt_op   = CNT_INC;
        end else if (opcode == OP_CDEC) begin
            op_class = CL_CNT;
            cnt_op   = CNT_DEC;
        end else if (opcode == OP_HALT) begin
            op_class = CL_HALT;
            is_halt  = 1'b1;
        end else begin
            is_illegal = 1'b1;
        end
    end

    assign alu_op = {3'b000, opcode};
    assign is_mul = (opcode == OP_MUL);
endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller: 4 cycles per instruction, +1 per memory wait, MUL adds its WAIT_ALU cycles.
// Stalls in FETCH until imem_valid and in WAIT_ALU until alu_done; ALU_SEQ_ILLEGAL_TRAP_EN halts on illegal opcodes.
module alu_sequencer
    import core_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    alu_sequencer_if.master bus,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP_ILLEGAL = 1'b1;
`else
    localparam bit TRAP_ILLEGAL = 1'b0;
`endif

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [13:0]     instr_q, instr_d;
    logic [7:0]      alu_op_q, alu_op_d;
    logic [2:0]      ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
    logic            alu_start_q, alu_start_d;
    logic            rf_we_q, rf_we_d;
    logic            flag_we_q, flag_we_d;
    logic [1:0]      cnt_op_q, cnt_op_d;
    logic            illegal_q, illegal_d;

    op_class_e  dec_class;
    logic [7:0] dec_alu_op;
    logic       dec_rf_we, dec_flag_we, dec_is_mul, dec_is_halt, dec_is_illegal;
    logic [1:0] dec_cnt_op;
    logic       reserved_unused;

    assign reserved_unused = ^bus.imem_data[15:14];

    alu_seq_decode u_decode (
        .opcode     (instr_q[F_OP_LSB +: 5]),
        .op_class   (dec_class),
        .alu_op     (dec_alu_op),
        .rf_we      (dec_rf_we),
        .flag_we    (dec_flag_we),
        .cnt_op     (dec_cnt_op),
        .is_mul     (dec_is_mul),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        alu_op_d    = alu_op_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        wa_d        = wa_q;
        illegal_d   = illegal_q;
        alu_start_d = 1'b0;
        rf_we_d     = 1'b0;
        flag_we_d   = 1'b0;
        cnt_op_d    = CNT_NONE;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
                    illegal_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (bus.imem_valid) begin
                    instr_d = bus.imem_data[13:0];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Operand/op fields are frozen here so the datapath sees them stable through WB.
                alu_op_d = dec_alu_op;
                ra_d     = instr_q[F_RA_LSB +: 3];
                rb_d     = instr_q[F_RB_LSB +: 3];
                wa_d     = instr_q[F_RD_LSB +: 3];
                if (dec_is_illegal) illegal_d = 1'b1;
                if (dec_is_halt || (TRAP_ILLEGAL && dec_is_illegal)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d     = ST_EXEC;
                    alu_start_d = (dec_class == CL_ALU) || (dec_class == CL_CMP);
                end
            end
            ST_EXEC: begin
                if (dec_is_mul) begin
                    state_d = ST_WAIT_ALU;
                end else begin
                    state_d   = ST_WB;
                    rf_we_d   = dec_rf_we;
                    flag_we_d = dec_flag_we;
                    cnt_op_d  = dec_cnt_op;
                end
            end
            ST_WAIT_ALU: begin
                if (bus.alu_done) begin
                    state_d = ST_WB;
                    rf_we_d = dec_rf_we;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            alu_op_q    <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            wa_q        <= '0;
            alu_start_q <= 1'b0;
            rf_we_q     <= 1'b0;
            flag_we_q   <= 1'b0;
            cnt_op_q    <= CNT_NONE;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            alu_op_q    <= alu_op_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            wa_q        <= wa_d;
            alu_start_q <= alu_start_d;
            rf_we_q     <= rf_we_d;
            flag_we_q   <= flag_we_d;
            cnt_op_q    <= cnt_op_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.imem_req  = (state_q == ST_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_start = alu_start_q;
    assign bus.rf_ra     = ra_q;
    assign bus.rf_rb     = rb_q;
    assign bus.rf_wa     = wa_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.flag_we   = flag_we_q;
    assign bus.cnt_op    = cnt_op_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted        = (state_q == ST_HALT);
    assign illegal       = illegal_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboarded bench for alu_sequencer: strobe events predicted per instruction, timing checked per scenario.
module tb_alu_sequencer;
    import core_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start2;
    logic busy, halted, illegal, busy2, halted2, illegal2;

    alu_sequencer_if #(.PC_W(8)) bus ();
    alu_sequencer_if #(.PC_W(2)) bus2 ();

    alu_sequencer #(.PC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .busy(busy), .halted(halted), .illegal(illegal)
    );
    alu_sequencer #(.PC_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2),
        .busy(busy2), .halted(halted2), .illegal(illegal2)
    );

    // Instruction memory with a programmable number of wait cycles per fetch.
    logic [15:0] mem [0:255];
    int mem_lat, wait_cnt;
    assign bus.imem_valid = bus.imem_req && (wait_cnt == mem_lat);
    assign bus.imem_data  = mem[bus.imem_addr];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (bus.imem_req && !bus.imem_valid) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // MUL unit: done arrives mul_delay cycles after alu_start; early_en adds a spurious done in EXEC.
    int   mul_delay, mul_cnt;
    logic early_en, mul_done;
    assign mul_done      = (mul_cnt == 1);
    assign bus.alu_done  = mul_done || (early_en && bus.alu_start);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mul_cnt <= 0;
        else if (bus.alu_start && bus.alu_op == 8'h03) mul_cnt <= mul_delay;
        else if (mul_cnt > 0) mul_cnt <= mul_cnt - 1;
    end

    assign bus2.imem_valid = bus2.imem_req;
    assign bus2.imem_data  = 16'h0000;
    assign bus2.alu_done   = 1'b0;

    typedef struct packed {
        logic [1:0] kind;   // 0 alu_start, 1 rf_we, 2 flag_we, 3 cnt_op
        logic [2:0] ra, rb, wa;
        logic [7:0] op;
        logic [1:0] cnt;
    } ev_t;

    ev_t sb[$];
    int  n_vec = 0, n_err = 0;

    task automatic push_instr(input logic [15:0] w);
        ev_t e;
        logic [4:0] op;
        op = w[4:0];
        e.ra = w[10:8]; e.rb = w[13:11]; e.wa = w[7:5]; e.op = {3'b000, op}; e.cnt = 2'b00;
        if ((op >= 5'h01 && op <= 5'h09) || op == 5'h10) begin
            e.kind = 2'd0; sb.push_back(e);
            e.kind = 2'd1; sb.push_back(e);
        end else if (op >= 5'h0A && op <= 5'h0C) begin
            e.kind = 2'd0; sb.push_back(e);
            e.kind = 2'd2; sb.push_back(e);
        end else if (op >= 5'h0D && op <= 5'h0F) begin
            e.kind = 2'd3; e.cnt = 2'(op - 5'h0C); sb.push_back(e);
        end
    endtask

    int  mon_ns;
    ev_t mon_obs, mon_exp;
    always @(negedge clk) begin
        if (rst_n) begin
            mon_ns = $countones({bus.alu_start, bus.rf_we, bus.flag_we, |bus.cnt_op});
            if (mon_ns > 1) begin
                n_vec++; n_err++;
                $display("FAIL strobe_overlap alu_start=%b rf_we=%b flag_we=%b cnt_op=%b required at most one",
                         bus.alu_start, bus.rf_we, bus.flag_we, bus.cnt_op);
            end else if (mon_ns == 1) begin
                mon_obs.kind = bus.alu_start ? 2'd0 : bus.rf_we ? 2'd1 : bus.flag_we ? 2'd2 : 2'd3;
                mon_obs.ra = bus.rf_ra; mon_obs.rb = bus.rf_rb; mon_obs.wa = bus.rf_wa;
                mon_obs.op = bus.alu_op; mon_obs.cnt = bus.cnt_op;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_strobe got=%h required none", mon_obs);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_obs !== mon_exp) begin
                        n_err++;
                        $display("FAIL strobe_event got=%h required=%h", mon_obs, mon_exp);
                    end
                end
            end
        end
    end

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the sampling point of cycle 1 (first FETCH cycle).
    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic check_sb_empty(input string name);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_sb_drained got=%0d pending required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [35:0] o;
        o = {busy, halted, illegal, bus.imem_req, bus.imem_addr, bus.alu_op, bus.alu_start,
             bus.rf_ra, bus.rf_rb, bus.rf_wa, bus.rf_we, bus.flag_we, bus.cnt_op};
        n_vec++;
        if (o !== '0) begin
            n_err++;
            $display("FAIL %s_outputs got=%h required=0", name, o);
        end
    endtask

    task automatic test_reset;
        do_reset;
        check_all_zero("reset");
    endtask

    task automatic test_alu_halt;
        int we_c, halt_c;
        mem[0] = 16'h0841; mem[1] = 16'h001F; mem_lat = 0;
        push_instr(mem[0]); push_instr(mem[1]);
        we_c = 0; halt_c = 0;
        pulse_start;
        for (int c = 1; c <= 12; c++) begin
            if (bus.rf_we && we_c == 0) we_c = c;
            if (halted && halt_c == 0) halt_c = c;
            if (c < 12) @(negedge clk);
        end
        n_vec++; if (we_c !== 4) begin n_err++; $display("FAIL add_rf_we_cycle got=%0d required=4", we_c); end
        n_vec++; if (halt_c !== 7) begin n_err++; $display("FAIL add_halt_cycle got=%0d required=7", halt_c); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL add_busy_after_halt got=%b required=0", busy); end
        check_sb_empty("add");
    endtask

    task automatic test_mul;
        int st_n, we_n, done_c, we_c, f2;
        mem[0] = 16'h23A3; mem[1] = 16'h001F; mem_lat = 0; mul_delay = 3; early_en = 1'b1;
        push_instr(mem[0]); push_instr(mem[1]);
        st_n = 0; we_n = 0; done_c = 0; we_c = 0; f2 = 0;
        pulse_start;
        for (int c = 1; c <= 14; c++) begin
            if (bus.alu_start) st_n++;
            if (bus.rf_we) we_n++;
            if (mul_done && done_c == 0) done_c = c;
            if (bus.rf_we && we_c == 0) we_c = c;
            if (bus.imem_req && bus.imem_addr == 8'd1 && f2 == 0) f2 = c;
            if (c < 14) @(negedge clk);
        end
        early_en = 1'b0;
        n_vec++; if (st_n !== 1) begin n_err++; $display("FAIL mul_alu_start_count got=%0d required=1", st_n); end
        n_vec++; if (done_c !== 6) begin n_err++; $display("FAIL mul_done_cycle got=%0d required=6", done_c); end
        n_vec++; if (we_c !== 7) begin n_err++; $display("FAIL mul_rf_we_cycle got=%0d required=7", we_c); end
        n_vec++; if (we_n !== 1) begin n_err++; $display("FAIL mul_rf_we_width got=%0d required=1", we_n); end
        n_vec++; if (f2 !== 8) begin n_err++; $display("FAIL mul_next_fetch_cycle got=%0d required=8", f2); end
        check_sb_empty("mul");
    endtask

    task automatic test_cmp_cnt;
        int we_n, fl_n, cnt_n, f2;
        mem[0] = 16'h1A2A; mem[1] = 16'h00CE; mem[2] = 16'h001F; mem_lat = 1;
        push_instr(mem[0]); push_instr(mem[1]); push_instr(mem[2]);
        we_n = 0; fl_n = 0; cnt_n = 0; f2 = 0;
        pulse_start;
        for (int c = 1; c <= 20; c++) begin
            if (bus.rf_we) we_n++;
            if (bus.flag_we) fl_n++;
            if (bus.cnt_op == 2'b10) cnt_n++;
            if (bus.imem_req && bus.imem_addr == 8'd1 && f2 == 0) f2 = c;
            if (c < 20) @(negedge clk);
        end
        mem_lat = 0;
        n_vec++; if (we_n !== 0) begin n_err++; $display("FAIL cmp_rf_we_count got=%0d required=0", we_n); end
        n_vec++; if (fl_n !== 1) begin n_err++; $display("FAIL cmp_flag_we_count got=%0d required=1", fl_n); end
        n_vec++; if (cnt_n !== 1) begin n_err++; $display("FAIL cnt_inc_count got=%0d required=1", cnt_n); end
        n_vec++; if (f2 !== 6) begin n_err++; $display("FAIL wait_next_fetch_cycle got=%0d required=6", f2); end
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL cmp_halted got=%b required=1", halted); end
        check_sb_empty("cmp");
    endtask

    task automatic test_illegal;
        int ill_c, f2, hc;
        mem[0] = 16'h0015; mem[1] = 16'h0000; mem[2] = 16'h001F; mem_lat = 0;
        ill_c = 0; f2 = 0;
        pulse_start;
        for (int c = 1; c <= 20; c++) begin
            if (illegal && ill_c == 0) ill_c = c;
            if (bus.imem_req && bus.imem_addr == 8'd1 && f2 == 0) f2 = c;
            if (c < 20) @(negedge clk);
        end
        n_vec++; if (ill_c !== 3) begin n_err++; $display("FAIL ill_set_cycle got=%0d required=3", ill_c); end
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL ill_halted got=%b required=1", halted); end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        n_vec++; if (bus.imem_addr !== 8'd0) begin n_err++; $display("FAIL ill_trap_addr got=%0d required=0", bus.imem_addr); end
        n_vec++; if (f2 !== 0) begin n_err++; $display("FAIL ill_trap_no_refetch got=%0d required=0", f2); end
`else
        n_vec++; if (bus.imem_addr !== 8'd2) begin n_err++; $display("FAIL ill_nop_final_addr got=%0d required=2", bus.imem_addr); end
        n_vec++; if (f2 !== 5) begin n_err++; $display("FAIL ill_nop_next_fetch got=%0d required=5", f2); end
`endif
        pulse_start;
        n_vec++; if ({illegal, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'd0}) begin
            n_err++; $display("FAIL ill_clear_on_start got=%b/%b/%0d required=0/1/0", illegal, bus.imem_req, bus.imem_addr);
        end
        hc = 0;
        while (!halted && hc < 40) begin @(negedge clk); hc++; end
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL ill_rerun_halt got=%b required=1", halted); end
        check_sb_empty("ill");
    endtask

    task automatic test_reset_mid;
        int hc;
        mem[0] = 16'h23A3; mem[1] = 16'h001F; mem_lat = 0; mul_delay = 20;
        push_instr(mem[0]);
        pulse_start;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        n_vec++; if (sb.size() !== 1) begin n_err++; $display("FAIL reset_mid_pending got=%0d required=1", sb.size()); end
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        mem[0] = 16'h001F;
        pulse_start;
        n_vec++; if ({busy, bus.imem_req, bus.imem_addr} !== {1'b1, 1'b1, 8'd0}) begin
            n_err++; $display("FAIL reset_mid_refetch got=%b/%b/%0d required=1/1/0", busy, bus.imem_req, bus.imem_addr);
        end
        hc = 0;
        while (!halted && hc < 10) begin @(negedge clk); hc++; end
        n_vec++; if (hc !== 2) begin n_err++; $display("FAIL reset_mid_halt_delay got=%0d required=2", hc); end
        check_sb_empty("reset_mid");
    endtask

    task automatic test_wrap;
        logic [1:0] exp_a;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            start2 = (c == 7 || c == 10);
            if ((c - 1) % 4 == 0) begin
                exp_a = 2'((c - 1) / 4);
                n_vec++;
                if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, exp_a}) begin
                    n_err++;
                    $display("FAIL wrap_fetch_c%0d got=%b/%0d required=1/%0d", c, bus2.imem_req, bus2.imem_addr, exp_a);
                end
            end
            if (c < 17) @(negedge clk);
        end
        start2 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h001F;
        mem_lat = 0; mul_delay = 3; early_en = 1'b0;
        test_reset;
        test_alu_halt;
        test_mul;
        test_cmp_cnt;
        test_illegal;
        test_reset_mid;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
